// File: rtl/stable_edge_counter.sv
// stable_edge_counter
// Glitch filter and rising-edge counter for the serial output of the
// upstream delay chain. A new level on `a` must hold for M consecutive
// samples before it is accepted. Acceptance then produces a one-cycle
// rise/fall pulse, and accepted rises bump a saturating W-bit count.

module stable_edge_counter #(
  parameter int M = 3,
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         a,
  input  logic         clear,
  output logic         level,
  output logic         rise,
  output logic         fall,
  output logic [W-1:0] count,
  output logic         busy
);

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    RISING  = 2'd1,
    HIGH    = 2'd2,
    FALLING = 2'd3
  } state_t;

  // M widened by one bit so that run+1 cannot overflow in the compare
  localparam logic [4:0] MLIM = 5'(M);

  state_t         state_q, state_d;
  logic [3:0]     run_q, run_d;
  logic           rise_q, rise_d;
  logic           fall_q, fall_d;
  logic [W-1:0]   count_q, count_d;
  logic [4:0]     runNext;

  assign runNext = {1'b0, run_q} + 5'd1;

  // Next-state, run length and pulse decisions for the debounce FSM
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      LOW: begin
        if (a) begin
          if (M == 1) begin
            state_d = HIGH;
            rise_d  = 1'b1;
          end else begin
            state_d = RISING;
            run_d   = 4'd1;
          end
        end
      end
      RISING: begin
        if (!a) begin
          state_d = LOW;
          run_d   = 4'd0;
        end else if (runNext < MLIM) begin
          run_d = runNext[3:0];
        end else begin
          state_d = HIGH;
          run_d   = 4'd0;
          rise_d  = 1'b1;
        end
      end
      HIGH: begin
        if (!a) begin
          if (M == 1) begin
            state_d = LOW;
            fall_d  = 1'b1;
          end else begin
            state_d = FALLING;
            run_d   = 4'd1;
          end
        end
      end
      FALLING: begin
        if (a) begin
          state_d = HIGH;
          run_d   = 4'd0;
        end else if (runNext < MLIM) begin
          run_d = runNext[3:0];
        end else begin
          state_d = LOW;
          run_d   = 4'd0;
          fall_d  = 1'b1;
        end
      end
      default: begin
        state_d = LOW;
        run_d   = 4'd0;
      end
    endcase
  end

  // Counter update: clear wins, otherwise count accepted rises and hold at all-ones
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (rise_d && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // State, run, pulse and count registers; reset discards any partial run
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= LOW;
      run_q   <= 4'd0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      count_q <= count_d;
    end
  end

  assign level = (state_q == HIGH) || (state_q == FALLING);
  assign busy  = (state_q == RISING) || (state_q == FALLING);
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign count = count_q;

endmodule

// File: tb/tb_stable_edge_counter.sv
// Testbench for stable_edge_counter (M=3, W=4).
// A driver applies directed and random stimulus on the falling clock edge and
// pushes the reference model's expected outputs into a queue; a monitor pops
// one entry after every rising edge and compares it with the DUT.

module tb_stable_edge_counter;

  localparam int M = 3;
  localparam int W = 4;
  localparam int CMAX = (1 << W) - 1;

  typedef struct {
    logic         level;
    logic         rise;
    logic         fall;
    logic [W-1:0] count;
    logic         busy;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         a     = 1'b0;
  logic         clear = 1'b0;
  logic         level, rise, fall, busy;
  logic [W-1:0] count;

  exp_t expQ[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: the samples seen since the last acceptance or reset
  logic hist[$];
  logic mLevel = 1'b0;
  int   mCount = 0;

  stable_edge_counter #(.M(M), .W(W)) dut (
    .clock (clock),
    .reset (reset),
    .a     (a),
    .clear (clear),
    .level (level),
    .rise  (rise),
    .fall  (fall),
    .count (count),
    .busy  (busy)
  );

  // Free-running clock, period 10
  always #5 clock = ~clock;

  // Compute what the DUT should show after the coming rising edge
  function automatic exp_t modelStep(input logic r, input logic av, input logic cv);
    exp_t e;
    logic accept;
    e.rise = 1'b0;
    e.fall = 1'b0;
    if (r) begin
      hist.delete();
      mLevel = 1'b0;
      mCount = 0;
    end else begin
      hist.push_back(av);
      if (hist.size() > M) void'(hist.pop_front());
      accept = (hist.size() == M);
      foreach (hist[i]) if (hist[i] == mLevel) accept = 1'b0;
      if (accept) begin
        mLevel = ~mLevel;
        e.rise = mLevel;
        e.fall = ~mLevel;
        hist.delete();
      end
      if (cv) mCount = 0;
      else if (e.rise && mCount < CMAX) mCount = mCount + 1;
    end
    e.level = mLevel;
    e.count = W'(mCount);
    e.busy  = (hist.size() > 0) && (hist[hist.size()-1] != mLevel);
    return e;
  endfunction

  task automatic applyStimulus(input logic r, input logic av, input logic cv);
    @(negedge clock);
    reset = r;
    a     = av;
    clear = cv;
    expQ.push_back(modelStep(r, av, cv));
  endtask

  task automatic checkOutput(input exp_t e);
    vectors++;
    if (level !== e.level) begin
      miscompares++;
      $display("[TB] FAIL level @%0t: got %b expected %b", $time, level, e.level);
    end
    if (rise !== e.rise) begin
      miscompares++;
      $display("[TB] FAIL rise @%0t: got %b expected %b", $time, rise, e.rise);
    end
    if (fall !== e.fall) begin
      miscompares++;
      $display("[TB] FAIL fall @%0t: got %b expected %b", $time, fall, e.fall);
    end
    if (count !== e.count) begin
      miscompares++;
      $display("[TB] FAIL count @%0t: got %0d expected %0d", $time, count, e.count);
    end
    if (busy !== e.busy) begin
      miscompares++;
      $display("[TB] FAIL busy @%0t: got %b expected %b", $time, busy, e.busy);
    end
  endtask

  // Monitor: every rising edge produces one output vector to check
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  // Driver: directed scenarios first, then a long random run
  initial begin
    // reset release with a held high, then a clean rise
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);
    // falling edge, then a rejected fall glitch
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    // rejected rise glitch from LOW
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
    // 20 clean pulses to reach and hold saturation
    for (int p = 0; p < 20; p++) begin
      repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    end
    // clear, build count to 5, then clear on the accepting edge of a rise
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int p = 0; p < 5; p++) begin
      repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    end
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
    // reset in FALLING with run=2, then a full new rise
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);
    // random run with sticky input, occasional clear and reset
    for (int i = 0; i < 3000; i++) begin
      logic av;
      av = ($urandom_range(0, 99) < 30) ? ~a : a;
      applyStimulus(($urandom_range(0, 249) == 0), av, ($urandom_range(0, 39) == 0));
    end
    repeat (3) @(posedge clock);
    #2;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
